// File: rtl/db_target_pkg.sv
// db_target_pkg: command/state types and strobe priority decode for the debug target model.
package db_target_pkg;
  typedef enum logic [2:0] {
    CMD_NONE, CMD_PAUSE, CMD_RESUME, CMD_RESET, CMD_REG_RD, CMD_REG_WR, CMD_MEM_RD, CMD_MEM_WR
  } cmd_t;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
  localparam logic [31:0] DEFAULT_SENTINEL = 32'h0000_FFFF;
  function automatic cmd_t decode_cmd(input logic p, input logic r, input logic rs,
                                      input logic rr, input logic rw, input logic mr,
                                      input logic mw);
    return p ? CMD_PAUSE : r ? CMD_RESUME : rs ? CMD_RESET : rr ? CMD_REG_RD :
           rw ? CMD_REG_WR : mr ? CMD_MEM_RD : mw ? CMD_MEM_WR : CMD_NONE;
  endfunction
endpackage

// File: rtl/db_target_pc_gen.sv
// db_target_pc_gen: emulated PC with step prescaler and wrap; breakpoint compare
// when DB_TARGET_BKPT_EN is defined.
module db_target_pc_gen #(
  parameter int MEM_WORDS      = 4096,
  parameter int PC_STEP_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        paused,
  input  logic        pc_clear,
`ifdef DB_TARGET_BKPT_EN
  input  logic        bkpt_en,
  input  logic [31:0] bkpt_addr,
  output logic        bkpt_trig,
  output logic        bkpt_hit,
`endif
  output logic [31:0] pc
);
  localparam logic [31:0] STEP_LAST = 32'(PC_STEP_CYCLES - 1);
  localparam logic [31:0] PC_LAST   = 32'(4 * MEM_WORDS - 4);
  logic [31:0] step_q, step_d, pc_q, pc_d, pc_inc;
  logic        step_pulse;
  always_comb begin
    step_pulse = !paused && !pc_clear && step_q == STEP_LAST;
    pc_inc     = (pc_q == PC_LAST) ? '0 : pc_q + 32'd4;
    step_d     = (pc_clear || step_pulse) ? '0 : paused ? step_q : step_q + 32'd1;
    pc_d       = pc_clear ? '0 : step_pulse ? pc_inc : pc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      pc_q   <= '0;
    end else begin
      step_q <= step_d;
      pc_q   <= pc_d;
    end
  end
`ifdef DB_TARGET_BKPT_EN
  logic hit_q;
  assign bkpt_trig = step_pulse && bkpt_en && pc_inc == bkpt_addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= 1'b0;
    else hit_q <= bkpt_trig;
  end
  assign bkpt_hit = hit_q;
`endif
  assign pc = pc_q;
endmodule

// File: rtl/db_target_model.sv
// db_target_model: cycle-accurate debug target answering the mcu_controller command interface.
// Optional breakpoint ports and self-pause are enabled by DB_TARGET_BKPT_EN.
module db_target_model
  import db_target_pkg::*;
#(
  parameter int          MEM_WORDS      = 4096,
  parameter int          NUM_REGS       = 32,
  parameter int          BUSY_CYCLES    = 16,
  parameter int          PC_STEP_CYCLES = 50000,
  parameter logic [31:0] SENTINEL       = DEFAULT_SENTINEL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_be,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_rd,
  output logic        busy,
  output logic        error,
  output logic        paused,
  output logic [31:0] pc
`ifdef DB_TARGET_BKPT_EN
  ,
  input  logic        bkpt_en,
  input  logic [31:0] bkpt_addr,
  output logic        bkpt_hit
`endif
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          RW        = $clog2(NUM_REGS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [31:0] REG_CNT   = 32'(NUM_REGS);
  localparam logic [31:0] BUSY_LOAD = 32'(BUSY_CYCLES);
  state_t      state_q, state_d;
  cmd_t        cmd;
  logic [31:0] cnt_q, cnt_d, rd_q, rd_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] mem [MEM_WORDS];
  logic        error_q, error_d, paused_q, paused_d;
  logic        accept, fault, mem_in, reg_in, aligned, mem_we, pc_clear, bkpt_set;
  logic [AW-1:0] mem_idx;
  logic [RW-1:0] reg_idx;
  always_comb begin
    cmd      = decode_cmd(pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr);
    accept   = valid && cmd != CMD_NONE && state_q == ST_IDLE;
    mem_idx  = addr[AW+1:2];
    reg_idx  = addr[RW-1:0];
    mem_in   = addr < MEM_BYTES;
    reg_in   = addr < REG_CNT;
    aligned  = addr[1:0] == 2'b00;
    fault    = (cmd == CMD_REG_RD || cmd == CMD_REG_WR) ? !reg_in :
               cmd == CMD_MEM_RD ? !(mem_in && aligned) :
               cmd == CMD_MEM_WR ? !(mem_in && (mem_be || aligned)) : 1'b0;
    mem_we   = accept && cmd == CMD_MEM_WR && !fault;
    pc_clear = accept && cmd == CMD_RESET;
    rd_d     = !(accept && (cmd == CMD_REG_RD || cmd == CMD_MEM_RD)) ? rd_q :
               fault ? SENTINEL : cmd == CMD_REG_RD ? regs_q[reg_idx] : mem[mem_idx];
    regs_d   = regs_q;
    if (accept && cmd == CMD_REG_WR && !fault && reg_idx != '0) regs_d[reg_idx] = d_in;
    // A command strobed while busy is the only non-accepted case that reaches here with cmd set
    error_d  = accept ? fault : (valid && cmd != CMD_NONE) ? 1'b1 : error_q;
    paused_d = (accept && cmd == CMD_PAUSE) ? 1'b1 : (accept && cmd == CMD_RESUME) ? 1'b0 : paused_q;
    paused_d = paused_d | bkpt_set;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (accept && BUSY_CYCLES != 0) begin
      state_d = ST_BUSY;
      cnt_d   = BUSY_LOAD;
    end else if (state_q == ST_BUSY) begin
      cnt_d   = cnt_q - 32'd1;
      state_d = (cnt_q == 32'd1) ? ST_IDLE : ST_BUSY;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_q     <= SENTINEL;
      error_q  <= 1'b0;
      paused_q <= 1'b0;
      regs_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      error_q  <= error_d;
      paused_q <= paused_d;
      regs_q   <= regs_d;
    end
  end
  // Big-endian lanes: byte offset 0 lives in bits [31:24]
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (mem_be) mem[mem_idx][{~addr[1:0], 3'b000} +: 8] <= d_in[7:0];
      else mem[mem_idx] <= d_in;
    end
  end
  db_target_pc_gen #(.MEM_WORDS(MEM_WORDS), .PC_STEP_CYCLES(PC_STEP_CYCLES)) u_pc_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .paused   (paused_q),
    .pc_clear (pc_clear),
`ifdef DB_TARGET_BKPT_EN
    .bkpt_en  (bkpt_en),
    .bkpt_addr(bkpt_addr),
    .bkpt_trig(bkpt_set),
    .bkpt_hit (bkpt_hit),
`endif
    .pc       (pc)
  );
`ifndef DB_TARGET_BKPT_EN
  assign bkpt_set = 1'b0;
`endif
  assign busy   = state_q == ST_BUSY;
  assign d_rd   = busy ? SENTINEL : rd_q;
  assign error  = error_q;
  assign paused = paused_q;
endmodule

// File: tb/tb_db_target_model.sv
// tb_db_target_model: directed and randomized checks against a behavioural reference model.
module tb_db_target_model;
  localparam int MW = 64, NR = 32, BC = 16, PS = 4;
  localparam logic [31:0] SENT = 32'h0000_FFFF;
  localparam logic [6:0] C_P = 7'b1000000, C_R = 7'b0100000, C_RS = 7'b0010000,
                         C_RR = 7'b0001000, C_RW = 7'b0000100, C_MR = 7'b0000010,
                         C_MW = 7'b0000001;
  logic clk = 0, rst_n = 0, valid = 0, pause = 0, resume = 0, reset = 0;
  logic reg_rd = 0, reg_wr = 0, mem_rd = 0, mem_wr = 0, mem_be = 0;
  logic [31:0] addr = 0, d_in = 0, d_rd, pc;
  logic busy, error, paused;
`ifdef DB_TARGET_BKPT_EN
  logic bkpt_en = 0, bkpt_hit;
  logic [31:0] bkpt_addr = 0;
`endif
  int checks = 0, fails = 0;
  // Reference model state: pc is derived from the number of running cycles since the last clear
  int m_left = 0, m_run = 0;
  logic m_err = 0, m_paused = 0, m_hit = 0;
  logic [31:0] m_rd = SENT;
  logic [31:0] m_regs [NR];
  logic [7:0]  mem_b [4*MW];

  db_target_model #(.MEM_WORDS(MW), .NUM_REGS(NR), .BUSY_CYCLES(BC), .PC_STEP_CYCLES(PS)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .pause(pause), .resume(resume), .reset(reset),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be),
    .addr(addr), .d_in(d_in), .d_rd(d_rd), .busy(busy), .error(error), .paused(paused), .pc(pc)
`ifdef DB_TARGET_BKPT_EN
    , .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .bkpt_hit(bkpt_hit)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_pc();
    return 32'(((m_run / PS) * 4) % (4 * MW));
  endfunction

  function automatic logic [31:0] exp_drd();
    return (m_left > 0) ? SENT : m_rd;
  endfunction

  task automatic model_reset();
    m_left = 0; m_run = 0; m_err = 0; m_paused = 0; m_hit = 0; m_rd = SENT;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
  endtask

  // Advance one clock, applying the current inputs to the model first
  task automatic step();
    logic acc, clr, was_paused, trig;
    int a;
    acc = 0; clr = 0; trig = 0; was_paused = m_paused; a = int'(addr);
    if (valid && (pause | resume | reset | reg_rd | reg_wr | mem_rd | mem_wr)) begin
      if (m_left > 0) m_err = 1;
      else begin
        acc = 1; m_err = 0;
        if (pause) m_paused = 1;
        else if (resume) m_paused = 0;
        else if (reset) clr = 1;
        else if (reg_rd) begin
          if (addr < NR) m_rd = m_regs[a]; else begin m_rd = SENT; m_err = 1; end
        end else if (reg_wr) begin
          if (addr >= NR) m_err = 1; else if (a != 0) m_regs[a] = d_in;
        end else if (mem_rd) begin
          if (addr < 4*MW && addr % 4 == 0) m_rd = {mem_b[a], mem_b[a+1], mem_b[a+2], mem_b[a+3]};
          else begin m_rd = SENT; m_err = 1; end
        end else begin
          if (addr >= 4*MW || (!mem_be && addr % 4 != 0)) m_err = 1;
          else if (mem_be) mem_b[a] = d_in[7:0];
          else {mem_b[a], mem_b[a+1], mem_b[a+2], mem_b[a+3]} = d_in;
        end
      end
    end
    if (acc) m_left = BC; else if (m_left > 0) m_left--;
    if (clr) m_run = 0;
    else if (!was_paused) begin
      m_run++;
`ifdef DB_TARGET_BKPT_EN
      if (bkpt_en && m_run % PS == 0 && exp_pc() == bkpt_addr) trig = 1;
`endif
    end
    m_hit = trig;
    if (trig) m_paused = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    valid = 0; {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = '0; mem_be = 0;
  endtask

  task automatic issue(input logic [6:0] bits, input logic be, input logic [31:0] a, input logic [31:0] d);
    valid = 1; {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = bits;
    mem_be = be; addr = a; d_in = d;
    step();
    clr_in();
  endtask

  task automatic settle();
    while (m_left > 0) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (paused !== 1'b0) begin fails++; $display("FAIL reset_paused: got %b want 0", paused); end
    checks++; if (pc !== 32'd0) begin fails++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (d_rd !== SENT) begin fails++; $display("FAIL reset_d_rd: got %h want %h", d_rd, SENT); end
  endtask

  task automatic test_mem_word();
    issue(C_MW, 0, 32'h10, 32'hA1B2C3D4);
    settle();
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL word_wr_error: got %b want 0", error); end
    issue(C_MR, 0, 32'h10, 0);
    for (int i = 0; i < BC; i++) begin
      checks++;
      if (busy !== 1'b1 || d_rd !== SENT) begin
        fails++; $display("FAIL busy_window[%0d]: busy=%b d_rd=%h want 1/%h", i, busy, d_rd, SENT);
      end
      step();
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_end: got %b want 0", busy); end
    checks++; if (d_rd !== 32'hA1B2C3D4) begin fails++; $display("FAIL word_rd: got %h want A1B2C3D4", d_rd); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL word_rd_error: got %b want 0", error); end
  endtask

  task automatic test_mem_byte();
    issue(C_MW, 1, 32'h13, 32'hFFFF_FF5A); settle();
    issue(C_MR, 0, 32'h10, 0); settle();
    checks++; if (d_rd !== 32'hA1B2C35A) begin fails++; $display("FAIL byte_wr_rd: got %h want A1B2C35A", d_rd); end
    issue(C_MW, 0, 32'h12, 32'h1111_1111); settle();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL misalign_wr_error: got %b want 1", error); end
    issue(C_MR, 0, 32'h10, 0); settle();
    checks++; if (d_rd !== 32'hA1B2C35A) begin fails++; $display("FAIL misalign_untouched: got %h want A1B2C35A", d_rd); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL error_clear: got %b want 0", error); end
    issue(C_MR, 0, 32'h100, 0); settle();
    checks++; if (error !== 1'b1 || d_rd !== SENT) begin
      fails++; $display("FAIL range_rd: error=%b d_rd=%h want 1/%h", error, d_rd, SENT); end
  endtask

  task automatic test_regs();
    issue(C_RW, 0, 0, 32'hFFFF_FFFF); settle();
    issue(C_RR, 0, 0, 0); settle();
    checks++; if (d_rd !== 32'd0 || error !== 1'b0) begin
      fails++; $display("FAIL reg0: d_rd=%h error=%b want 0/0", d_rd, error); end
    issue(C_RW, 0, 31, 32'hCAFE_0031); settle();
    issue(C_RR, 0, 31, 0); settle();
    checks++; if (d_rd !== 32'hCAFE_0031) begin fails++; $display("FAIL reg31: got %h want CAFE0031", d_rd); end
    issue(C_RR, 0, 32, 0); settle();
    checks++; if (error !== 1'b1 || d_rd !== SENT) begin
      fails++; $display("FAIL reg_range: error=%b d_rd=%h want 1/%h", error, d_rd, SENT); end
  endtask

  task automatic test_pc();
    logic [31:0] saved;
    logic frozen;
    do_reset();
    repeat (12) step();
    checks++; if (pc !== 32'd12) begin fails++; $display("FAIL pc_12: got %0d want 12", pc); end
    issue(C_P, 0, 0, 0); settle();
    checks++; if (paused !== 1'b1) begin fails++; $display("FAIL pause: got %b want 1", paused); end
    saved = pc; frozen = 1;
    repeat (20) begin step(); if (pc !== saved) frozen = 0; end
    checks++; if (!frozen) begin fails++; $display("FAIL pc_frozen: got %0d want %0d", pc, saved); end
    issue(C_R, 0, 0, 0); settle();
    checks++; if (pc !== exp_pc() || paused !== 1'b0) begin
      fails++; $display("FAIL pc_resume: pc=%0d paused=%b want %0d/0", pc, paused, exp_pc()); end
    issue(C_RS, 0, 0, 0);
    checks++; if (pc !== 32'd0 || paused !== 1'b0) begin
      fails++; $display("FAIL reset_cmd: pc=%0d paused=%b want 0/0", pc, paused); end
    settle();
  endtask

  task automatic test_priority();
    issue(C_P | C_MW, 0, 32'h10, 32'h0);
    checks++; if (paused !== 1'b1) begin fails++; $display("FAIL prio_pause: got %b want 1", paused); end
    settle();
    issue(C_MR, 0, 32'h10, 0); settle();
    checks++; if (d_rd !== 32'hA1B2C35A) begin fails++; $display("FAIL prio_mem: got %h want A1B2C35A", d_rd); end
    issue(C_R, 0, 0, 0); settle();
    issue(C_MR, 0, 32'h10, 0);
    issue(C_RR, 0, 1, 0);
    checks++; if (error !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL drop_busy: error=%b busy=%b want 1/1", error, busy); end
    settle();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL drop_sticky: got %b want 1", error); end
    issue(7'b0, 0, 0, 0);
    checks++; if (error !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL empty_strobe: error=%b busy=%b want 1/0", error, busy); end
  endtask

  task automatic test_pc_wrap();
    issue(C_RS, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step();
      checks++; if (pc !== exp_pc()) begin fails++; $display("FAIL pc_track[%0d]: got %0d want %0d", i, pc, exp_pc()); end
      if (m_run == 4 * MW) begin
        checks++; if (pc !== 32'd0) begin fails++; $display("FAIL pc_wrap: got %0d want 0", pc); end
      end
    end
  endtask

`ifdef DB_TARGET_BKPT_EN
  task automatic test_bkpt();
    logic found;
    found = 0;
    bkpt_en = 1; bkpt_addr = 32'd8;
    issue(C_RS, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step();
      checks++; if (bkpt_hit !== m_hit) begin fails++; $display("FAIL bkpt_hit[%0d]: got %b want %b", i, bkpt_hit, m_hit); end
      if (m_hit && !found) begin
        found = 1;
        checks++; if (paused !== 1'b1 || pc !== 32'd8) begin
          fails++; $display("FAIL bkpt_pause: paused=%b pc=%0d want 1/8", paused, pc); end
      end
    end
    checks++; if (!found) begin fails++; $display("FAIL bkpt_timeout: hit=0 want 1"); end
    bkpt_en = 0;
    settle();
    issue(C_R, 0, 0, 0); settle();
  endtask
`endif

  task automatic test_reset_mid_busy();
    issue(C_MR, 0, 32'h10, 0);
    repeat (3) step();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (busy !== 1'b0 || pc !== 32'd0) begin
      fails++; $display("FAIL async_reset: busy=%b pc=%0d want 0/0", busy, pc); end
    checks++; if (d_rd !== SENT || error !== 1'b0) begin
      fails++; $display("FAIL async_reset_rd: d_rd=%h error=%b want %h/0", d_rd, error, SENT); end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    int sel;
    for (int w = 0; w < MW; w++) begin issue(C_MW, 0, 32'(w * 4), $urandom); settle(); end
    for (int i = 0; i < 2000; i++) begin
      valid = ($urandom % 3) == 0;
      sel = $urandom % 10;
      {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} =
        (sel < 7) ? 7'(7'b1 << ($urandom % 7)) : (sel < 9) ? 7'($urandom) : 7'b0;
      mem_be = $urandom % 2;
      sel = $urandom % 4;
      addr = (sel == 0) ? 32'($urandom % 40) : (sel == 3) ? $urandom : 32'($urandom % 264);
      d_in = $urandom;
      step();
      checks++; if (busy !== (m_left > 0)) begin fails++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_left > 0); end
      checks++; if (error !== m_err) begin fails++; $display("FAIL rnd_error[%0d]: got %b want %b", i, error, m_err); end
      checks++; if (paused !== m_paused) begin fails++; $display("FAIL rnd_paused[%0d]: got %b want %b", i, paused, m_paused); end
      checks++; if (pc !== exp_pc()) begin fails++; $display("FAIL rnd_pc[%0d]: got %0d want %0d", i, pc, exp_pc()); end
      checks++; if (d_rd !== exp_drd()) begin fails++; $display("FAIL rnd_d_rd[%0d]: got %h want %h", i, d_rd, exp_drd()); end
    end
    clr_in();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mem_word();
    test_mem_byte();
    test_regs();
    test_pc();
    test_priority();
    test_pc_wrap();
`ifdef DB_TARGET_BKPT_EN
    test_bkpt();
`endif
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
